// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to unsigned binary converter.
//
// One digit is folded in per clock, most significant digit first, using a
// multiply-by-10 accumulate (acc*8 + acc*2 + digit). A conversion takes
// DIGITS cycles in CONV plus one DONE cycle; the minimum spacing between
// accepted starts is DIGITS+2 cycles.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous, active-high reset
//   start_i    conversion request, sampled only in IDLE
//   bcd_in_i   packed BCD, [3:0] is the least significant digit
//   busy_o     high while converting (registered)
//   done_o     one-cycle pulse when bin_out_o / error_o update
//   bin_out_o  registered binary result, held between conversions
//   error_o    last conversion saw a digit > 9
//
// Optional build macro BCD2BIN_AUTO_EN: free-running mode where start_i is
// ignored and IDLE always starts a new conversion, so the result tracks a
// live bcd_in_i with period DIGITS+2 and done_o pulses every period.

module bcd_to_bin #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   bcd_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BIN_W-1:0]      bin_out_o,
  output logic                  error_o
);

  localparam int unsigned ACC_W = BIN_W + 4;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [4*DIGITS-1:0]   shadow_q;
  logic [ACC_W-1:0]      acc_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  bad_q;
  logic                  busy_q;
  logic                  done_q;
  logic [BIN_W-1:0]      bin_q;
  logic                  err_q;

  logic                  start_c;
  logic [3:0]            digit_c;
  logic [ACC_W-1:0]      acc_d;
  logic                  bad_d;
  logic                  last_c;

  // Effective start request: forced high in free-running mode.
`ifdef BCD2BIN_AUTO_EN
  logic unused_start;
  assign unused_start = start_i;
  assign start_c      = 1'b1;
`else
  assign start_c      = start_i;
`endif

  // Current digit and next accumulator value (acc*10 + digit).
  always_comb begin
    digit_c = shadow_q[4*idx_q +: 4];
    acc_d   = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit_c);
    bad_d   = bad_q | (digit_c > 4'd9);
    last_c  = (idx_q == '0);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_c) begin
            shadow_q <= bcd_in_i;
            acc_q    <= '0;
            idx_q    <= IDX_W'(DIGITS - 1);
            bad_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CONV;
          end
        end
        S_CONV: begin
          acc_q <= acc_d;
          bad_q <= bad_d;
          idx_q <= idx_q - IDX_W'(1);
          if (last_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            // An invalid digit keeps the previous result and flags error.
            if (bad_d) begin
              err_q <= 1'b1;
            end else begin
              bin_q <= acc_d[BIN_W-1:0];
              err_q <= 1'b0;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign bin_out_o = bin_q;
  assign error_o   = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed steps plus random BCD words
// checked against an arithmetic reference (sum of digit * 10^position).

module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;
  localparam int unsigned BCD_W  = 4 * DIGITS;

  logic              clk;
  logic              rst;
  logic              start;
  logic [BCD_W-1:0]  bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              error;

  int errors = 0;
  int checks = 0;

  // Expected held outputs.
  logic [BIN_W-1:0]  exp_bin;
  logic              exp_err;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .bcd_in_i  (bcd_in),
    .busy_o    (busy),
    .done_o    (done),
    .bin_out_o (bin_out),
    .error_o   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decimal value of a BCD word and whether any digit is out of range.
  function automatic void ref_model(input logic [BCD_W-1:0] bcd,
                                    output int unsigned val, output bit bad);
    int unsigned p;
    logic [BCD_W-1:0] w;
    logic [3:0] d;
    val = 0;
    bad = 1'b0;
    p   = 1;
    w   = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d   = w[3:0];
      w   = w >> 4;
      if (d > 4'd9) bad = 1'b1;
      val = val + int'(d) * p;
      p   = p * 10;
    end
  endfunction

  function automatic void predict(input logic [BCD_W-1:0] bcd);
    int unsigned v;
    bit b;
    ref_model(bcd, v, b);
    if (b) begin
      exp_err = 1'b1;
    end else begin
      exp_bin = BIN_W'(v % (1 << BIN_W));
      exp_err = 1'b0;
    end
  endfunction

  // One conversion with cycle-exact checks of busy/done timing. If glitch is
  // set, bcd_in changes and start is pulsed again while busy.
  task automatic run_conv(input logic [BCD_W-1:0] bcd, input bit glitch, input string tag);
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    predict(bcd);
    for (int c = 1; c <= int'(DIGITS); c++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_nodone"}, 32'(done), 0);
      if (glitch && c == 1) begin
        bcd_in = 12'h789;
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_off"}, 32'(busy), 0);
    chk({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
    chk({tag, "_err"}, 32'(error), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  // Wait (bounded) for a done pulse; returns cycles waited.
  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  initial begin
    int cyc;
    logic [BCD_W-1:0] r;
    rst     = 1'b1;
    start   = 1'b0;
    bcd_in  = '0;
    exp_bin = '0;
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_err", 32'(error), 0);

`ifdef BCD2BIN_AUTO_EN
    // Free-running: start stays low, result tracks bcd_in.
    bcd_in = 12'h000;
    wait_done(20, cyc);
    wait_done(20, cyc);
    chk("auto_period0", 32'(cyc), DIGITS + 2);
    chk("auto_bin000", 32'(bin_out), 0);
    bcd_in = 12'h998;
    wait_done(20, cyc);
    wait_done(20, cyc);
    chk("auto_period1", 32'(cyc), DIGITS + 2);
    chk("auto_bin998", 32'(bin_out), 998);
    bcd_in = 12'h999;
    wait_done(20, cyc);
    wait_done(20, cyc);
    chk("auto_period2", 32'(cyc), DIGITS + 2);
    chk("auto_bin999", 32'(bin_out), 999);
    chk("auto_err", 32'(error), 0);
`else
    run_conv(12'h999, 1'b0, "c999");
    run_conv(12'h5A3, 1'b0, "c5A3");
    chk("c5A3_hold", 32'(bin_out), 999);
    run_conv(12'h123, 1'b0, "c123");
    run_conv(12'h000, 1'b0, "c000");
    run_conv(12'h001, 1'b0, "c001");
    run_conv(12'h500, 1'b0, "c500");
    run_conv(12'h456, 1'b1, "c456");
    // Ignored second start must not produce another done.
    repeat (4) begin
      @(negedge clk);
      chk("c456_nodone", 32'(done), 0);
    end
    chk("c456_bin", 32'(bin_out), 456);

    // Reset mid-conversion aborts it.
    @(negedge clk);
    bcd_in = 12'h999;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_bin = '0;
    exp_err = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_bin", 32'(bin_out), 0);
    chk("abort_err", 32'(error), 0);
    repeat (DIGITS + 2) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done), 0);
    end
    run_conv(12'h042, 1'b0, "c042");

    // Random words, occasionally with an invalid digit.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if ($urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
        else                           r[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run_conv(r, 1'b0, "rand");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
